// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared definitions for the run sequencer.
//   - default widths and timeout for the run_sequencer parameters
//   - FSM state encoding, also exported on the fsm_state debug port
package run_seq_pkg;

  localparam int DEF_RUNS_W         = 4;
  localparam int DEF_CNT_W          = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: clearable, enabled up-counter that sticks at all-ones.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset, forces count to 0
//   clear  - synchronous clear to 0 (wins over enable)
//   enable - count up by one this cycle
//   count  - current value, saturates at all-ones
module run_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: issues a batch of request pulses to a processor, one per
// run, and measures how many cycles each run takes to report done.
// Ports:
//   clk          - rising-edge clock
//   reset        - asynchronous active-low reset
//   start        - host request to begin a batch (ignored while busy)
//   num_runs     - runs in the batch, latched when start is accepted
//   dut_done     - processor completion flag (only observed in WAIT)
//   dut_req      - one-cycle request pulse to the processor
//   busy         - high in REQ, WAIT and GAP
//   run_idx      - index of the current / most recent run, from 0
//   cycles       - length of the most recently completed run
//   cycles_valid - one-cycle pulse when cycles updates
//   all_done     - batch completed, held until the next accepted start
//   timeout      - sticky: a run exceeded TIMEOUT_CYCLES
//   fsm_state    - debug view of the FSM state
//
// Processor handshake: dut_req is a single-cycle pulse (no ready). The run
// length is the number of cycles from the dut_req cycle to the cycle in
// which dut_done is seen high while in WAIT; dut_done is a level that is
// only sampled in WAIT, so a done held over GAP/REQ cannot end a new run
// early.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int RUNS_W         = DEF_RUNS_W,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [RUNS_W-1:0] num_runs,
  input  logic              dut_done,
  output logic              dut_req,
  output logic              busy,
  output logic [RUNS_W-1:0] run_idx,
  output logic [CNT_W-1:0]  cycles,
  output logic              cycles_valid,
  output logic              all_done,
  output logic              timeout,
  output state_t            fsm_state
);

  // The counter is cleared during REQ, so in the k-th WAIT cycle it holds
  // k-1. Reaching TIMEOUT_CYCLES therefore means the counter is about to
  // leave TIMEOUT_CYCLES-1 with no done seen.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [RUNS_W-1:0]   runs_q;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_inc;
  logic                cnt_clear;
  logic                cnt_enable;
  logic                last_run;
  logic                wait_expired;

  assign fsm_state    = state;
  assign cnt_clear    = (state == ST_REQ);
  assign cnt_enable   = (state == ST_WAIT);
  // Run length includes the done cycle itself, hence count + 1 (saturating).
  assign count_inc    = (count == '1) ? count : count + CNT_W'(1);
  assign last_run     = (run_idx == (runs_q - RUNS_W'(1)));
  assign wait_expired = (count == TIMEOUT_LAST);

  run_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .count  (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      runs_q       <= '0;
      dut_req      <= 1'b0;
      busy         <= 1'b0;
      run_idx      <= '0;
      cycles       <= '0;
      cycles_valid <= 1'b0;
      all_done     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      dut_req      <= 1'b0;
      cycles_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_FINISH, ST_FAULT: begin
          if (start) begin
            runs_q  <= num_runs;
            run_idx <= '0;
            timeout <= 1'b0;
            if (num_runs != '0) begin
              state    <= ST_REQ;
              dut_req  <= 1'b1;
              busy     <= 1'b1;
              all_done <= 1'b0;
            end else begin
              // Empty batch completes immediately without touching the DUT.
              state    <= ST_FINISH;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done beats the timeout when both land in the same cycle.
          if (dut_done) begin
            cycles       <= count_inc;
            cycles_valid <= 1'b1;
            if (last_run) begin
              state    <= ST_FINISH;
              busy     <= 1'b0;
              all_done <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end else if (wait_expired) begin
            state   <= ST_FAULT;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        ST_GAP: begin
          run_idx <= run_idx + RUNS_W'(1);
          state   <= ST_REQ;
          dut_req <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter RUNS_W, default 4, SHALL set the width of the run-count and run-index fields.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the per-run cycle counter.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the WAIT-state cycle limit before a fault is declared.
REQ-004 The block SHALL have exactly one clock, clk (input, 1 bit), which is rising-edge active.
REQ-005 The reset port, reset (input, 1 bit), SHALL be asynchronous and active-low.
REQ-006 Input start (1 bit) SHALL be the host request to begin a batch, sampled on the clock edge.
REQ-007 Input num_runs (RUNS_W bits) SHALL be the number of processor runs in the batch, latched at start.
REQ-008 Input dut_done (1 bit) SHALL be the processor's completion flag.
REQ-009 Output dut_req (1 bit) SHALL be the request pulse to the processor.
REQ-010 Output busy (1 bit) SHALL be high while a batch is in progress.
REQ-011 Output run_idx (RUNS_W bits) SHALL be the index of the current or most recent run, counting from 0.
REQ-012 Output cycles (CNT_W bits) SHALL be the measured length of the most recently completed run.
REQ-013 Output cycles_valid (1 bit) SHALL pulse high for one cycle when cycles updates.
REQ-014 Output all_done (1 bit) SHALL indicate that the batch completed.
REQ-015 Output timeout (1 bit) SHALL be a sticky flag indicating that a run exceeded TIMEOUT_CYCLES.

Function
REQ-016 The FSM SHALL have the states IDLE, REQ, WAIT, GAP, FINISH and FAULT.
REQ-017 In IDLE, FINISH or FAULT, start=1 with num_runs!=0 SHALL latch num_runs, clear run_idx, all_done and timeout, and enter REQ on the next edge.
REQ-018 start=1 with num_runs=0 SHALL enter FINISH directly with no dut_req pulse.
REQ-019 In REQ, dut_req SHALL be high for exactly one cycle, the cycle counter SHALL clear to 0, and the FSM SHALL enter WAIT.
REQ-020 dut_req SHALL be low in every state other than REQ.
REQ-021 In WAIT, the counter SHALL increment by 1 every cycle and saturate at all-ones.
REQ-022 When dut_done=1 in WAIT: cycles SHALL take the counter value plus 1 (saturating), cycles_valid SHALL pulse on the following cycle, and the FSM SHALL enter FINISH if run_idx equals latched num_runs minus 1, otherwise GAP.
REQ-023 GAP SHALL last one cycle, increment run_idx, and return to REQ, so consecutive dut_req pulses are at least 2 cycles apart.
REQ-024 If the counter reaches TIMEOUT_CYCLES in WAIT without dut_done, the FSM SHALL enter FAULT and set timeout=1.
REQ-025 If dut_done=1 in the same cycle the counter reaches TIMEOUT_CYCLES, done SHALL take priority and timeout SHALL stay 0.
REQ-026 In FINISH, all_done SHALL be held at 1 and busy at 0 until the next accepted start.
REQ-027 In FAULT, busy SHALL be 0 and run_idx SHALL hold the failing run's index.
REQ-028 busy SHALL be 1 exactly in REQ, WAIT and GAP.
REQ-029 start SHALL be ignored while busy=1, and num_runs changes while busy SHALL have no effect.
REQ-030 dut_done SHALL be ignored in every state other than WAIT, including a done held high across GAP into REQ.

Reset
REQ-031 When reset=0, the block SHALL asynchronously force the FSM to IDLE and drive dut_req, busy, run_idx, cycles, cycles_valid, all_done, timeout and the counter to 0.
REQ-032 Reset asserted mid-run SHALL abort the batch, and no dut_req SHALL be issued until a new start is accepted after release.

Structure
REQ-033 Package run_seq_pkg SHALL hold the FSM state enum and the default constants for RUNS_W, CNT_W and TIMEOUT_CYCLES.
REQ-034 Sub-module run_cycle_counter SHALL provide a clear, enable and saturate counter of CNT_W bits, instantiated once.

Verification
REQ-035 The bench SHALL check: num_runs=1, dut_done pulsed 7 cycles after dut_req -> one dut_req pulse, cycles=7, cycles_valid pulses once, all_done=1, busy=0.
REQ-036 The bench SHALL check: num_runs=3, done latencies 4/10/2 -> three dut_req pulses, each at least 2 cycles apart, cycles values 4,10,2 in order, run_idx ends at 2, then all_done.
REQ-037 The bench SHALL check: TIMEOUT_CYCLES=20 with dut_done never asserted -> FAULT after 20 WAIT cycles, timeout=1, all_done=0, run_idx=0; a new start clears timeout.
REQ-038 The bench SHALL check: dut_done on the exact timeout cycle -> cycles=TIMEOUT_CYCLES and timeout=0.
REQ-039 The bench SHALL check: start pulsed again mid-batch and num_runs changed from 3 to 1 -> batch still runs 3 times.
REQ-040 The bench SHALL check: reset=0 during WAIT of run 1 of 2 -> all outputs 0 immediately, and no dut_req until the next start; start with num_runs=0 -> all_done=1 with no dut_req.
